// File: rtl/ifetcher_pkg.sv
// Shared types and constants for the instruction-fetch PC controller.
package ifetcher_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } pc_state_e;

    localparam int          IF_FETCH_BYTES = 16;
    localparam int          IF_LOFF        = $clog2(IF_FETCH_BYTES);
    localparam logic [31:0] IF_RESET_PC    = 32'h0000_0000;

endpackage

// File: rtl/ifetcher_watchdog.sv
// Outstanding-request watchdog: counts enabled cycles, clear wins, registered terminal pulse.
// Latency: o_timeout one cycle after the terminal increment; never back-pressures.
module ifetcher_watchdog #(
    parameter int TOW     = 8,
    parameter int TIMEOUT = 200
) (
    input  logic iClk,
    input  logic iReset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire,
    output logic o_timeout
);
    import ifetcher_pkg::*;

    localparam logic [TOW-1:0] TC = TOW'(TIMEOUT - 1);

    logic [TOW-1:0] r_cnt;
    logic           r_timeout;
    logic           w_inc;

    assign w_inc    = i_en & ~i_clr;
    assign o_expire = w_inc & (r_cnt == TC);
    assign o_timeout = r_timeout;

    // Expiry clears the counter, so it can never reach saturation.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= o_expire;
            if (i_clr || o_expire)
                r_cnt <= '0;
            else if (w_inc)
                r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ifetcher_pcctrl.sv
// Fetch PC controller: line-advance, redirect with stale-response drain, watchdog halt.
// Latency: PC/offset update one cycle after iNext/iRedirect; oDiscard is combinational.
module ifetcher_pcctrl #(
    parameter int          PCW         = 32,
    parameter int          FETCH_BYTES = ifetcher_pkg::IF_FETCH_BYTES,
    parameter logic [PCW-1:0] RESET_PC = PCW'(ifetcher_pkg::IF_RESET_PC),
    parameter int          TOW         = 8,
    parameter int          TIMEOUT     = 200
) (
    input  logic                               iClk,
    input  logic                               iReset,
    input  logic                               iNext,
    input  logic                               iCountEn,
    input  logic                               iCountDone,
    input  logic                               iRedirect,
    input  logic [PCW-1:0]                     iRedirectPC,
    output logic [PCW-1:0]                     oPC,
    output logic [$clog2(FETCH_BYTES/4)-1:0]   oStartOffset,
    output logic                               oDiscard,
    output logic                               oTimeout,
    output logic                               oHalted,
    output logic [1:0]                         oState
);
    import ifetcher_pkg::*;

    localparam int LOFF = $clog2(FETCH_BYTES);
    localparam int SOW  = LOFF - 2;

    pc_state_e          r_state, w_state_nxt;
    logic [PCW-1:0]     r_pc, w_pc_nxt;
    logic [SOW-1:0]     r_off, w_off_nxt;
    logic               r_halted, w_halted_nxt;
    logic               w_expire;
    logic               w_wd_en;
    logic               w_wd_clr;
    logic [PCW-1:0]     w_redir_line;
    logic [SOW-1:0]     w_redir_off;
    logic [1:0]         w_unused_bytebits;

    assign w_redir_line      = {iRedirectPC[PCW-1:LOFF], {LOFF{1'b0}}};
    assign w_redir_off       = iRedirectPC[LOFF-1:2];
    assign w_unused_bytebits = iRedirectPC[1:0];

    assign w_wd_en  = iCountEn & ~iCountDone & (r_state != ST_HALT);
    assign w_wd_clr = iCountDone | iRedirect | ~iCountEn;

    ifetcher_watchdog #(
        .TOW     (TOW),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .iClk      (iClk),
        .iReset    (iReset),
        .i_en      (w_wd_en),
        .i_clr     (w_wd_clr),
        .o_expire  (w_expire),
        .o_timeout (oTimeout)
    );

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_state  <= ST_RUN;
            r_pc     <= RESET_PC;
            r_off    <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_off    <= w_off_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Priority: redirect, then watchdog expiry, then line advance / drain completion.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_off_nxt    = r_off;
        w_halted_nxt = r_halted;
        case (r_state)
            ST_RUN: begin
                if (iRedirect) begin
                    w_pc_nxt  = w_redir_line;
                    w_off_nxt = w_redir_off;
                    if (iCountEn && !iNext)
                        w_state_nxt = ST_DRAIN;
                end else if (w_expire) begin
                    w_state_nxt  = ST_HALT;
                    w_halted_nxt = 1'b1;
                end else if (iNext) begin
                    w_pc_nxt  = r_pc + PCW'(FETCH_BYTES);
                    w_off_nxt = '0;
                end
            end
            ST_DRAIN: begin
                if (iRedirect) begin
                    w_pc_nxt  = w_redir_line;
                    w_off_nxt = w_redir_off;
                    if (iNext)
                        w_state_nxt = ST_RUN;
                end else if (w_expire) begin
                    w_state_nxt  = ST_HALT;
                    w_halted_nxt = 1'b1;
                end else if (iNext) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALT: begin
                if (iRedirect) begin
                    w_pc_nxt     = w_redir_line;
                    w_off_nxt    = w_redir_off;
                    w_state_nxt  = ST_RUN;
                    w_halted_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Nothing is written while halted, so the mask is held low there.
    assign oDiscard     = (r_state != ST_HALT) & ((r_state == ST_DRAIN) | iRedirect);
    assign oPC          = r_pc;
    assign oStartOffset = r_off;
    assign oHalted      = r_halted;
    assign oState       = r_state;

endmodule

// File: tb/tb_ifetcher_pcctrl.sv
// Randomised + directed bench for ifetcher_pcctrl with a queue-based scoreboard.
module tb_ifetcher_pcctrl;

    localparam int TIMEOUT = 5;
    localparam int FB      = 16;

    logic        clk = 1'b0;
    logic        rst, nx, ce, cd, rd;
    logic [31:0] rpc;
    logic [31:0] o_pc;
    logic [1:0]  o_off;
    logic        o_disc, o_to, o_halt;
    logic [1:0]  o_state;

    always #5 clk = ~clk;

    ifetcher_pcctrl #(
        .PCW(32), .FETCH_BYTES(FB), .RESET_PC(32'h0), .TOW(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .iClk(clk), .iReset(rst), .iNext(nx), .iCountEn(ce), .iCountDone(cd),
        .iRedirect(rd), .iRedirectPC(rpc), .oPC(o_pc), .oStartOffset(o_off),
        .oDiscard(o_disc), .oTimeout(o_to), .oHalted(o_halt), .oState(o_state)
    );

    typedef struct {
        logic [31:0] pc;
        int          off;
        int          st;
        bit          halt;
        bit          to;
        bit          disc;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 = running, 1 = waiting to drop a stale response, 2 = halted.
    logic [31:0] m_pc;
    int m_off, m_mode, m_cnt;
    bit m_halt, m_to;

    task automatic model_reset();
        m_pc = 32'h0; m_off = 0; m_mode = 0; m_cnt = 0; m_halt = 0; m_to = 0;
    endtask

    task automatic cyc(input bit r, input bit n, input bit e, input bit d,
                       input bit re, input logic [31:0] tgt);
        exp_t x;
        bit expire;
        @(posedge clk);
        #1;
        rst = r; nx = n; ce = e; cd = d; rd = re; rpc = tgt;
        if (r) begin
            model_reset();
            x = '{m_pc, m_off, m_mode, m_halt, m_to, 1'b0};
            q.push_back(x);
        end else begin
            x = '{m_pc, m_off, m_mode, m_halt, m_to,
                  (m_mode != 2) && (m_mode == 1 || re)};
            q.push_back(x);
            expire = (m_mode != 2) && !re && e && !d && (m_cnt == TIMEOUT - 1);
            m_to = expire;
            if (re || !e || d)   m_cnt = 0;
            else if (m_mode == 2) m_cnt = m_cnt;
            else if (expire)      m_cnt = 0;
            else                  m_cnt = m_cnt + 1;
            if (re) begin
                m_pc  = tgt - (tgt % FB);
                m_off = (tgt % FB) / 4;
                if (m_mode == 0)      m_mode = (e && !n) ? 1 : 0;
                else if (m_mode == 1) m_mode = n ? 0 : 1;
                else begin            m_mode = 0; m_halt = 0; end
            end else if (expire) begin
                m_mode = 2; m_halt = 1;
            end else if (n && m_mode == 0) begin
                m_pc  = m_pc + FB;
                m_off = 0;
            end else if (n && m_mode == 1) begin
                m_mode = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc",      o_pc,            e.pc);
                chk("offset",  32'(o_off),      32'(e.off));
                chk("state",   32'(o_state),    32'(e.st));
                chk("halted",  32'(o_halt),     32'(e.halt));
                chk("timeout", 32'(o_to),       32'(e.to));
                chk("discard", 32'(o_disc),     32'(e.disc));
            end
        end
    end

    initial begin : stim
        int budget;
        rst = 1'b1; nx = 0; ce = 0; cd = 0; rd = 0; rpc = '0;
        model_reset();
        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        // line advance
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // redirect with request outstanding -> drain
        cyc(0, 0, 1, 0, 1, 32'h1238);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // redirect coinciding with a response
        cyc(0, 1, 1, 0, 1, 32'h400);
        cyc(0, 0, 0, 0, 0, 0);
        // watchdog expiry, ignored responses, redirect out of halt
        repeat (7) cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h83);
        cyc(0, 0, 0, 0, 0, 0);
        // redirect during drain, then PC wrap and last-slot offset
        cyc(0, 0, 1, 0, 1, 32'h2000);
        cyc(0, 0, 1, 0, 1, 32'h3004);
        cyc(0, 1, 1, 0, 1, 32'hFFFF_FFF0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0, 0);
        // reset in the middle of a drain
        cyc(0, 0, 1, 0, 1, 32'h5550);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // randomised traffic
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom % 200) == 0, ($urandom % 3) == 0, ($urandom % 4) != 0,
                ($urandom % 5) == 0, ($urandom % 12) == 0, $urandom);
        end
        cyc(0, 0, 0, 0, 0, 0);
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected records left, required 0", q.size());
        end
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
